axi_lite_mem_master: RTL and testbench



---
 rtl/axi_lite_mem_master.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_lite_mem_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_master.sv
// Single-outstanding core request port to AXI4-Lite master bridge with a fixed base address.
// Optional build macro MISALIGN_CHECK_EN rejects misaligned accesses locally without bus traffic.
module axi_lite_mem_master #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
   parameter logic [2:0]  PROT      = 3'b000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] axi_araddr,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   output logic [2:0]  axi_arprot,
   input  logic [31:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   output logic [31:0] axi_awaddr,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [2:0]  axi_awprot,
   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic [1:0]  axi_bresp,
   input  logic        axi_bvalid,
   output logic        axi_bready
);

   typedef enum logic [2:0] {
      IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, ERR_RESP
   } state_t;

   state_t      state_q, state_d;
   logic        req_ready_q, req_ready_d;
   logic [31:0] araddr_q, araddr_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic        awvalid_q, awvalid_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic        misalign_c;
   logic        aw_now_c, w_now_c;

`ifdef MISALIGN_CHECK_EN
   // Strobes below the byte offset would spill outside the addressed word lane.
   logic [3:0] low_mask_c;
   assign low_mask_c = 4'((4'd1 << req_addr[1:0]) - 4'd1);
   assign misalign_c = (req_addr[1:0] != 2'd0) &&
                       (!req_we || ((req_wstrb & low_mask_c) != 4'd0));
`else
   assign misalign_c = 1'b0;
`endif

   assign aw_now_c = aw_done_q || (awvalid_q && axi_awready);
   assign w_now_c  = w_done_q  || (wvalid_q  && axi_wready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         araddr_q     <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         awaddr_q     <= '0;
         awvalid_q    <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         wvalid_q     <= 1'b0;
         bready_q     <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         araddr_q     <= araddr_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         awaddr_q     <= awaddr_d;
         awvalid_q    <= awvalid_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         wvalid_q     <= wvalid_d;
         bready_q     <= bready_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      req_ready_d  = req_ready_q;
      araddr_d     = araddr_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      awaddr_d     = awaddr_q;
      awvalid_d    = awvalid_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      wvalid_d     = wvalid_q;
      bready_d     = bready_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;

      case (state_q)
         IDLE: begin
            if (req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               if (misalign_c) begin
                  state_d = ERR_RESP;
               end else if (req_we) begin
                  state_d   = WR_ADDR;
                  awaddr_d  = req_addr + BASE_ADDR;
                  wdata_d   = req_wdata;
                  wstrb_d   = req_wstrb;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
               end else begin
                  state_d   = RD_ADDR;
                  araddr_d  = req_addr + BASE_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         RD_ADDR: begin
            if (axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (axi_rvalid) begin
               rready_d     = 1'b0;
               resp_rdata_d = axi_rdata;
               resp_err_d   = (axi_rresp != 2'b00);
               resp_valid_d = 1'b1;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         WR_ADDR: begin
            // Each channel retires independently; move on once both have.
            if (awvalid_q && axi_awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && axi_wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_now_c && w_now_c) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               bready_d  = 1'b1;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: begin
            if (axi_bvalid) begin
               bready_d     = 1'b0;
               resp_err_d   = (axi_bresp != 2'b00);
               resp_valid_d = 1'b1;
               req_ready_d  = 1'b1;
               state_d      = IDLE;
            end
         end
         ERR_RESP: begin
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            req_ready_d  = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign axi_araddr  = araddr_q;
   assign axi_arvalid = arvalid_q;
   assign axi_arprot  = PROT;
   assign axi_rready  = rready_q;
   assign axi_awaddr  = awaddr_q;
   assign axi_awvalid = awvalid_q;
   assign axi_awprot  = PROT;
   assign axi_wdata   = wdata_q;
   assign axi_wstrb   = wstrb_q;
   assign axi_wvalid  = wvalid_q;
   assign axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Directed-vector bench for axi_lite_mem_master with a cycle-stepped AXI slave model.
module tb_axi_lite_mem_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_wstrb;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
   logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
   logic        axi_bvalid, axi_bready;
   logic [2:0]  axi_arprot, axi_awprot;
   logic [1:0]  axi_rresp, axi_bresp;
   logic [3:0]  axi_wstrb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_lite_mem_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_arprot(axi_arprot),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
      .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_awprot(axi_awprot),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
      .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
      logic [31:0] rdata;
      logic [1:0]  resp;
      logic [31:0] exp_addr;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic slave_idle();
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0;
      axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = '0;
   endtask

   // Called at a negedge; presents the request and steps the slave until resp_valid.
   task automatic run_vec(input vec_t v, input string tag);
      int ar_w = 0, r_w = 0, aw_w = 0, w_w = 0, b_w = 0;
      int ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
      logic addr_ok = 1'b1, proto_ok = 1'b1, rr_low = 1'b1, wd_ok = 1'b1;
      logic done = 1'b0;
      chk({tag, " req_ready_idle"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
      req_wdata = v.wdata; req_wstrb = v.wstrb;
      slave_idle();
      @(negedge clk);
      req_valid = 1'b0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         slave_idle();
         if (cyc == 0) chk({tag, " resp_single"}, 32'(resp_valid), 32'd0);
         if (resp_valid) begin
            done = 1'b1;
         end else begin
            if (req_ready) rr_low = 1'b0;
            if (axi_arvalid) begin
               if (ar_hs > 0 || axi_araddr !== v.exp_addr) proto_ok = 1'b0;
               if (axi_araddr !== v.exp_addr) addr_ok = 1'b0;
               axi_arready = (ar_w == v.ar_dly);
               if (axi_arready) ar_hs++;
               ar_w++;
            end
            if (axi_rready) begin
               axi_rvalid = (r_w == v.r_dly);
               if (axi_rvalid) begin
                  axi_rdata = v.rdata; axi_rresp = v.resp; r_hs++;
               end
               r_w++;
            end
            if (axi_awvalid) begin
               if (aw_hs > 0) proto_ok = 1'b0;
               if (axi_awaddr !== v.exp_addr) addr_ok = 1'b0;
               axi_awready = (aw_w == v.aw_dly);
               if (axi_awready) aw_hs++;
               aw_w++;
            end
            if (axi_wvalid) begin
               if (w_hs > 0) proto_ok = 1'b0;
               if (axi_wdata !== v.wdata || axi_wstrb !== v.wstrb) wd_ok = 1'b0;
               axi_wready = (w_w == v.w_dly);
               if (axi_wready) w_hs++;
               w_w++;
            end
            if (axi_bready) begin
               if (!(aw_hs == 1 && w_hs == 1)) proto_ok = 1'b0;
               axi_bvalid = (b_w == v.b_dly);
               if (axi_bvalid) begin
                  axi_bresp = v.resp; b_hs++;
               end
               b_w++;
            end
            @(negedge clk);
         end
      end
      chk({tag, " completed"}, 32'(done), 32'd1);
      chk({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
      chk({tag, " resp_err"}, 32'(resp_err), 32'(v.exp_err));
      chk({tag, " req_ready_busy_low"}, 32'(rr_low), 32'd1);
      chk({tag, " addr_stable"}, 32'(addr_ok), 32'd1);
      chk({tag, " handshake_order"}, 32'(proto_ok), 32'd1);
      if (v.we) begin
         chk({tag, " aw_hs"}, 32'(aw_hs), 32'd1);
         chk({tag, " w_hs"}, 32'(w_hs), 32'd1);
         chk({tag, " b_hs"}, 32'(b_hs), 32'd1);
         chk({tag, " w_payload"}, 32'(wd_ok), 32'd1);
         chk({tag, " no_ar"}, 32'(ar_hs), 32'd0);
      end else begin
         chk({tag, " ar_hs"}, 32'(ar_hs), 32'd1);
         chk({tag, " r_hs"}, 32'(r_hs), 32'd1);
         chk({tag, " no_aw"}, 32'(aw_hs), 32'd0);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, " valids"}, 32'({axi_arvalid, axi_awvalid, axi_wvalid, resp_valid}), 32'd0);
      chk({tag, " readies"}, 32'({axi_rready, axi_bready}), 32'd0);
      chk({tag, " araddr"}, axi_araddr, 32'd0);
      chk({tag, " awaddr"}, axi_awaddr, 32'd0);
      chk({tag, " wdata"}, axi_wdata, 32'd0);
      chk({tag, " wstrb"}, 32'(axi_wstrb), 32'd0);
      chk({tag, " resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, " resp_err"}, 32'(resp_err), 32'd0);
   endtask

   initial begin
      logic seen;
      rst = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      slave_idle();

      //          we    addr           wdata          wstrb ar r aw w b rdata         resp   exp_addr       err   exp_rdata
      vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 32'h0000_1010, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0, 0, 2, 0, 0, 32'h0,         2'b00, 32'h0000_1020, 1'b0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 32'h0000_0040, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 0, 0, 32'h0,         2'b10, 32'h0000_1040, 1'b1, 32'hDEAD_BEEF};
      vecs[3] = '{1'b0, 32'h0000_0084, 32'h0,         4'h0, 5, 3, 0, 0, 0, 32'hCAFE_F00D, 2'b00, 32'h0000_1084, 1'b0, 32'hCAFE_F00D};
      vecs[4] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 1, 1, 0, 0, 0, 32'h0000_55AA, 2'b11, 32'h0000_1008, 1'b1, 32'h0000_55AA};
      vecs[5] = '{1'b0, 32'hFFFF_F000, 32'h0,         4'h0, 0, 2, 0, 0, 0, 32'h0BAD_F00D, 2'b00, 32'h0000_0000, 1'b0, 32'h0BAD_F00D};
      vecs[6] = '{1'b1, 32'h0000_0100, 32'h0000_BEEF, 4'h3, 0, 0, 1, 3, 2, 32'h0,         2'b00, 32'h0000_1100, 1'b0, 32'h0BAD_F00D};

      repeat (2) @(negedge clk);
      chk_reset_values("reset");
      chk("prot", 32'({axi_arprot, axi_awprot}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Each vector starts on the negedge where the previous resp_valid is seen (back-to-back).
      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Asynchronous reset while waiting in RD_DATA.
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0010;
      slave_idle();
      @(negedge clk);
      req_valid = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
         axi_arready = axi_arvalid;
         @(negedge clk);
         axi_arready = 1'b0;
         seen = axi_rready;
      end
      chk("rst_mid reached RD_DATA", 32'(seen), 32'd1);
      #2 rst = 1'b1;
      #1 chk_reset_values("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_vec(vecs[0], "post_rst");

`ifdef MISALIGN_CHECK_EN
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0003;
      slave_idle();
      @(negedge clk);
      req_valid = 1'b0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 2 && !seen; cyc++) begin
         chk("misalign no_arvalid", 32'(axi_arvalid), 32'd0);
         if (resp_valid) seen = 1'b1;
         else @(negedge clk);
      end
      chk("misalign resp_valid", 32'(seen), 32'd1);
      chk("misalign resp_err", 32'(resp_err), 32'd1);
`endif

      @(negedge clk);
      chk("idle resp_valid low", 32'(resp_valid), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
